// File: rtl/prio_encoder_stream_pkg.sv
// Shared definitions for the streaming priority encoder and its combinational core.
// Index N-1 has top priority, which matches the 2-to-4 decoder mapping (code 3 <-> y[3]).
package prio_enc_pkg;

    localparam int DEFAULT_N = 4;
    localparam int MAX_N     = 32;
    localparam int MAX_W     = $clog2(MAX_N);

    // Output-stage state: EMPTY means nothing is presented, FULL means out_code holds a request.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic int code_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Returns the highest set index, or 0 when the vector is all-zero.
    function automatic logic [MAX_W-1:0] prio_index(input logic [MAX_N-1:0] vec);
        logic [MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) idx = MAX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_encoder_stream_comb.sv
// Combinational N-to-log2(N) priority encoder: highest set bit wins.
// any_valid qualifies idx, which reads 0 for an all-zero input.
module prio_enc_comb
    import prio_enc_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = code_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any_valid
);

    logic [MAX_N-1:0] vec_wide;

    assign vec_wide  = MAX_N'(vec);
    assign idx       = W'(prio_index(vec_wide));
    assign any_valid = |vec;

endmodule

// File: rtl/prio_encoder_stream.sv
// Streaming priority encoder: request pulses collect in a pending register and the
// highest pending index is presented one at a time on a valid/ready output.
module prio_encoder_stream
    import prio_enc_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = code_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    output logic [W-1:0] out_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending_o,
    output logic         overflow_o
);

    state_e       state, state_nxt;
    logic [N-1:0] pending, pending_nxt;
    logic [N-1:0] cand;
    logic [W-1:0] sel;
    logic         cand_any;
    logic         load;

    // New pulses are merged with what is already waiting before picking a winner.
    assign cand = pending | req_i;

    prio_enc_comb #(.N(N)) u_enc (
        .vec       (cand),
        .idx       (sel),
        .any_valid (cand_any)
    );

    assign load = ((state == ST_EMPTY) || out_ready) && cand_any;

    always_comb begin
        state_nxt   = state;
        pending_nxt = cand;
        if (load) pending_nxt = cand & ~(N'(1) << sel);
        case (state)
            ST_EMPTY: if (cand_any) state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !cand_any) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // A re-request of the presented line is not pending, so it counts as a new event;
    // overflow only flags pulses landing on lines already waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            pending    <= '0;
            out_code   <= '0;
            overflow_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            overflow_o <= |(req_i & pending);
            if (load) out_code <= sel;
        end
    end

    assign out_valid = (state == ST_FULL);
    assign pending_o = pending;

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Directed bench for prio_encoder_stream (N=4): expected codes go into a scoreboard
// queue and a monitor pops one on every valid/ready handshake.
module tb_prio_encoder_stream;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_i;
    logic [1:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pending_o;
    logic       overflow_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    prio_encoder_stream #(.N(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .out_code   (out_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pending_o  (pending_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] dec2to4(input logic [1:0] a);
        logic [3:0] one;
        one = 4'b0001;
        return one << a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs are stable at the falling edge, so valid&&ready here means a handshake next edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got code %0d with empty queue at %0t", out_code, $time);
            end else begin
                chk("sb_code", 32'(out_code), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset with requests asserted, then idle
        rst_n = 1'b0; req_i = 4'b1111; out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_pending", 32'(pending_o), 0);
            chk("rst_overflow", 32'(overflow_o), 0);
            step();
        end
        rst_n = 1'b1; req_i = 4'b0000;
        step(); step();
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_pending", 32'(pending_o), 0);
        chk("idle_overflow", 32'(overflow_o), 0);

        // 2. single request, consumer ready
        out_ready = 1'b1; req_i = 4'b0100; exp_q.push_back(2'd2);
        step(); req_i = 4'b0000;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_code", 32'(out_code), 2);
        step();
        chk("single_drain_valid", 32'(out_valid), 0);
        chk("single_drain_pending", 32'(pending_o), 0);

        // 3. multi-hot with backpressure, then 3,1,0 back to back
        out_ready = 1'b0; req_i = 4'b1011;
        exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
        step(); req_i = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_code", 32'(out_code), 3);
            chk("bp_pending", 32'(pending_o), 32'h3);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_pending", 32'(pending_o), 32'h1);
        step(); step();
        chk("bp_done_valid", 32'(out_valid), 0);

        // 4. overflow on a repeated pending line
        out_ready = 1'b0; req_i = 4'b1000; exp_q.push_back(2'd3);
        step();
        req_i = 4'b0001; exp_q.push_back(2'd0);
        step(); req_i = 4'b0000;
        chk("ovf_first_none", 32'(overflow_o), 0);
        chk("ovf_pending", 32'(pending_o), 32'h1);
        step();
        req_i = 4'b0001;
        step(); req_i = 4'b0000;
        chk("ovf_pulse", 32'(overflow_o), 1);
        step();
        chk("ovf_one_cycle", 32'(overflow_o), 0);
        chk("ovf_hold_code", 32'(out_code), 3);
        out_ready = 1'b1;
        step(); step();
        chk("ovf_done_valid", 32'(out_valid), 0);
        chk("ovf_done_pending", 32'(pending_o), 0);

        // 5. loop-back from the 2-to-4 decoder, one pulse per cycle
        for (int i = 0; i < 4; i++) begin
            req_i = dec2to4(2'(i)); exp_q.push_back(2'(i));
            step();
            chk("loop_valid", 32'(out_valid), 1);
            chk("loop_code", 32'(out_code), 32'(i));
            chk("loop_overflow", 32'(overflow_o), 0);
        end
        req_i = 4'b0000;
        step();
        chk("loop_done_valid", 32'(out_valid), 0);
        chk("sb_drained", 32'(exp_q.size()), 0);

        // 6. asynchronous reset between edges
        out_ready = 1'b0; req_i = 4'b1011;
        step(); req_i = 4'b0000;
        chk("arst_pre_valid", 32'(out_valid), 1);
        chk("arst_pre_pending", 32'(pending_o), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_pending", 32'(pending_o), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_after_valid", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
